// File: rtl/div_share_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// div_share_pkg : FSM encoding and helpers for the shared iterative divider
// Rev 1.0
//------------------------------------------------------------------------------
package div_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_REQ = 32;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

    // Scan downwards so the requester closest after ptr is the last to write pick.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int nreq);
        int pick;
        int idx;
        pick = ptr;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= nreq) begin
                idx = (ptr + i) % nreq;
                if (req[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// div_iter_core : unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
//------------------------------------------------------------------------------
module div_iter_core
    import div_share_pkg::*;
#(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 step,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 last,
    output logic                 dbz,
    output logic [DATAWIDTH-1:0] quo_res,
    output logic [DATAWIDTH-1:0] rem_res
);
    localparam int CNT_W = cnt_width(DATAWIDTH);

    logic [DATAWIDTH-1:0] pr;
    logic [DATAWIDTH-1:0] qr;
    logic [DATAWIDTH-1:0] br;
    logic [CNT_W-1:0]     cnt;
    logic                 zero_div;
    logic [DATAWIDTH:0]   shifted;
    logic [DATAWIDTH:0]   diff;
    logic                 fits;

    // qr starts as the dividend and fills with quotient bits as it shifts out.
    always_comb begin
        shifted = {pr, qr[DATAWIDTH-1]};
        diff    = shifted - {1'b0, br};
        fits    = ~diff[DATAWIDTH];
        last    = step & (zero_div | (cnt == CNT_W'(DATAWIDTH - 1)));
        dbz     = zero_div;
        quo_res = zero_div ? '1 : {qr[DATAWIDTH-2:0], fits};
        rem_res = zero_div ? qr : (fits ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0]);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pr       <= '0;
            qr       <= '0;
            br       <= '0;
            cnt      <= '0;
            zero_div <= 1'b0;
        end else if (start) begin
            pr       <= '0;
            qr       <= a;
            br       <= b;
            cnt      <= '0;
            zero_div <= (b == '0);
        end else if (step && !zero_div) begin
            pr  <= fits ? diff[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
            qr  <= {qr[DATAWIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// div_share_ctrl : round-robin sharing of one iterative divider among NREQ users
// Rev 1.0
//------------------------------------------------------------------------------
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int NREQ      = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic [DATAWIDTH-1:0]      quo,
    output logic [DATAWIDTH-1:0]      rem,
    output logic                      div_by_zero,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NREQ);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     win;
    logic                 start;
    logic                 step;
    logic                 last;
    logic                 core_dbz;
    logic [DATAWIDTH-1:0] core_quo;
    logic [DATAWIDTH-1:0] core_rem;
    logic [DATAWIDTH-1:0] a_sel;
    logic [DATAWIDTH-1:0] b_sel;

    always_comb begin
        win   = IDX_W'(rr_next(MAX_REQ'(req), int'(ptr), NREQ));
        start = (state == ST_IDLE) && (|req);
        step  = (state == ST_CALC);
        a_sel = a_in[win*DATAWIDTH +: DATAWIDTH];
        b_sel = b_in[win*DATAWIDTH +: DATAWIDTH];
    end

    div_iter_core #(
        .DATAWIDTH (DATAWIDTH)
    ) u_core (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .step    (step),
        .a       (a_sel),
        .b       (b_sel),
        .last    (last),
        .dbz     (core_dbz),
        .quo_res (core_quo),
        .rem_res (core_rem)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NREQ - 1);
            idx         <= '0;
            gnt         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            quo         <= '0;
            rem         <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_CALC;
                        gnt   <= NREQ'(1) << win;
                        ptr   <= win;
                        idx   <= win;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (last) begin
                        state       <= ST_DONE;
                        done        <= NREQ'(1) << idx;
                        quo         <= core_quo;
                        rem         <= core_rem;
                        div_by_zero <= core_dbz;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// tb_div_share_ctrl : directed bench with a transaction-level reference model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_div_share_ctrl;
    localparam int DW = 8;
    localparam int NR = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] a_in = '0;
    logic [NR*DW-1:0] b_in = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [DW-1:0]    quo;
    logic [DW-1:0]    rem;
    logic             div_by_zero;
    logic             busy;

    div_share_ctrl #(.DATAWIDTH(DW), .NREQ(NR)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .quo(quo), .rem(rem),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit auto_drop = 1'b1;

    always @(posedge Clk) cyc++;

    // Reference model: a transaction either waits for a grant or counts edges
    // since capture; results come straight from / and %.
    logic [NR-1:0] m_gnt = '0, m_done = '0;
    logic [DW-1:0] m_quo = '0, m_rem = '0;
    logic          m_dbz = 1'b0, m_busy = 1'b0;
    int  m_ptr = NR - 1, m_idx = 0, m_t = 0, m_lat = 0, m_qv = 0, m_rv = 0, w = 0, av = 0, bv = 0;
    bit  m_act = 1'b0, m_zv = 1'b0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_gnt = '0; m_done = '0; m_quo = '0; m_rem = '0; m_dbz = 1'b0; m_busy = 1'b0;
            m_ptr = NR - 1; m_act = 1'b0; m_t = 0;
        end else begin
            m_gnt  = '0;
            m_done = '0;
            if (!m_act) begin
                if (req != '0) begin
                    w = -1;
                    for (int i = 1; i <= NR; i++)
                        if (w < 0 && req[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
                    av    = int'(a_in[w*DW +: DW]);
                    bv    = int'(b_in[w*DW +: DW]);
                    m_zv  = (bv == 0);
                    m_qv  = m_zv ? (1 << DW) - 1 : av / bv;
                    m_rv  = m_zv ? av : av % bv;
                    m_lat = m_zv ? 1 : DW;
                    m_ptr = w; m_idx = w; m_t = 0; m_act = 1'b1;
                    m_gnt = NR'(1) << w;
                    m_busy = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t == m_lat) begin
                    m_done = NR'(1) << m_idx;
                    m_quo  = DW'(m_qv);
                    m_rem  = DW'(m_rv);
                    m_dbz  = m_zv;
                end else if (m_t == m_lat + 1) begin
                    m_act  = 1'b0;
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        n_cmp++;
        if ({gnt, done, busy, div_by_zero, quo, rem} !== {m_gnt, m_done, m_busy, m_dbz, m_quo, m_rem}) begin
            n_err++;
            $display("FAIL cycle_compare @%0d: dut gnt=%b done=%b busy=%b dbz=%b quo=%0d rem=%0d | want gnt=%b done=%b busy=%b dbz=%b quo=%0d rem=%0d",
                     cyc, gnt, done, busy, div_by_zero, quo, rem, m_gnt, m_done, m_busy, m_dbz, m_quo, m_rem);
        end
    end

    // Event logs for the directed literal checks.
    int            g_idx[$], g_cyc[$], d_cyc[$];
    logic [NR-1:0] g_vec[$], d_vec[$];
    logic [DW-1:0] d_quo[$], d_rem[$];
    logic          d_dbz[$];

    always @(negedge Clk) begin
        if (|gnt) begin
            g_vec.push_back(gnt);
            g_cyc.push_back(cyc);
            for (int i = 0; i < NR; i++) if (gnt[i]) g_idx.push_back(i);
        end
        if (|done) begin
            d_vec.push_back(done); d_cyc.push_back(cyc);
            d_quo.push_back(quo); d_rem.push_back(rem); d_dbz.push_back(div_by_zero);
        end
    end

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); g_vec.delete();
        d_cyc.delete(); d_vec.delete(); d_quo.delete(); d_rem.delete(); d_dbz.delete();
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic set_op(input int k, input int a, input int b);
        a_in[k*DW +: DW] = DW'(a);
        b_in[k*DW +: DW] = DW'(b);
    endtask

    task automatic wait_logs(input string nm, input int ng, input int nd, input int maxc);
        int i;
        i = 0;
        while ((g_idx.size() < ng || d_vec.size() < nd) && i < maxc) begin
            step();
            i++;
        end
        check({nm, "_timeout"}, 64'((g_idx.size() >= ng) && (d_vec.size() >= nd)), 64'd1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 100) begin
            step();
            i++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_quo", 64'(quo), 64'd0);
        Rst = 1'b1;
        step();

        // Fairness from reset with edge operands.
        set_op(0, 100, 7); set_op(1, 255, 1); set_op(2, 3, 200); set_op(3, 0, 9);
        req = 4'b1111;
        wait_logs("fair4", 4, 4, 100);
        for (int i = 0; i < 4; i++) check("fair_order", 64'(g_idx[i]), 64'(i));
        for (int i = 1; i < 4; i++) check("fair_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd10);
        check("q_100_7", 64'(d_quo[0]), 64'd14);  check("r_100_7", 64'(d_rem[0]), 64'd2);
        check("q_255_1", 64'(d_quo[1]), 64'd255); check("r_255_1", 64'(d_rem[1]), 64'd0);
        check("q_3_200", 64'(d_quo[2]), 64'd0);   check("r_3_200", 64'(d_rem[2]), 64'd3);
        check("q_0_9", 64'(d_quo[3]), 64'd0);     check("r_0_9", 64'(d_rem[3]), 64'd0);

        wait_idle(); clear_logs();
        set_op(0, 20, 3); set_op(2, 81, 9);
        req = 4'b0101;
        wait_logs("pair", 2, 2, 60);
        check("pair_first", 64'(g_idx[0]), 64'd0);
        check("pair_second", 64'(g_idx[1]), 64'd2);

        // Single divide.
        wait_idle(); clear_logs();
        set_op(0, 100, 7);
        req = 4'b0001;
        wait_logs("single", 1, 1, 40);
        check("single_gnt", 64'(g_vec[0]), 64'b0001);
        check("single_gnt_count", 64'(g_vec.size()), 64'd1);
        check("single_latency", 64'(d_cyc[0] - g_cyc[0]), 64'd8);
        check("single_done", 64'(d_vec[0]), 64'b0001);
        check("single_quo", 64'(d_quo[0]), 64'd14);
        check("single_rem", 64'(d_rem[0]), 64'd2);
        check("single_dbz", 64'(d_dbz[0]), 64'd0);

        // Divide by zero.
        wait_idle(); clear_logs();
        set_op(1, 55, 0);
        req = 4'b0010;
        wait_logs("dbz", 1, 1, 20);
        check("dbz_latency", 64'(d_cyc[0] - g_cyc[0]), 64'd1);
        check("dbz_done", 64'(d_vec[0]), 64'b0010);
        check("dbz_quo", 64'(d_quo[0]), 64'd255);
        check("dbz_rem", 64'(d_rem[0]), 64'd55);
        check("dbz_flag", 64'(d_dbz[0]), 64'd1);

        // Reset in the middle of CALC.
        wait_idle(); clear_logs();
        set_op(1, 200, 7);
        req = 4'b0010;
        wait_logs("midrst_gnt", 1, 0, 20);
        repeat (4) step();
        #2 Rst = 1'b0;
        #1;
        check("midrst_outputs", 64'({gnt, done, busy, div_by_zero, quo, rem}), 64'd0);
        repeat (3) step();
        #2 Rst = 1'b1;
        step();
        check("midrst_no_done", 64'(d_vec.size()), 64'd0);
        clear_logs();
        set_op(3, 9, 4); set_op(0, 17, 5);
        req = 4'b1001;
        wait_logs("post_rst", 2, 2, 60);
        check("post_rst_first", 64'(g_idx[0]), 64'd0);
        check("post_rst_second", 64'(g_idx[1]), 64'd3);

        // Stale request held through done.
        wait_idle(); clear_logs();
        auto_drop = 1'b0;
        set_op(2, 50, 5);
        req = 4'b0100;
        wait_logs("stale_regrant", 2, 1, 40);
        req = '0;
        auto_drop = 1'b1;
        wait_logs("stale_done2", 2, 2, 40);
        check("stale_regrant_gap", 64'(g_cyc[1] - d_cyc[0]), 64'd2);
        check("stale_gnt2", 64'(g_vec[1]), 64'b0100);
        check("stale_done2", 64'(d_vec[1]), 64'b0100);
        check("stale_quo", 64'(d_quo[1]), 64'd10);
        check("stale_rem", 64'(d_rem[1]), 64'd0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_share_ctrl.md
# div_share_ctrl

Round-robin arbiter and sequencer that shares one iterative restoring divider between `NREQ` requesters. It replaces a combinational DATAWIDTH-bit `/` per consumer with a single shared, one-bit-per-cycle unit. It sits between datapath stages that issue divide operations and returns quotient and remainder, with a per-requester completion pulse.

## Interface
- `DATAWIDTH`, 64: operand, quotient and remainder width.
- `NREQ`, 4: number of requesters (≥2).
- `Clk  in  1`: rising-edge clock.
- `Rst  in  1`: asynchronous, active-low reset.
- `req  in  NREQ`: request per requester. Held with operands stable until `gnt` is seen.
- `a_in  in  NREQ*DATAWIDTH`: dividends, requester k at bits [k*DATAWIDTH +: DATAWIDTH].
- `b_in  in  NREQ*DATAWIDTH`: divisors, same packing.
- `gnt  out  NREQ`: one-hot, one-cycle pulse. Operands of that requester were captured on the preceding edge.
- `done  out  NREQ`: one-hot, one-cycle pulse. `quo`/`rem`/`div_by_zero` are valid for that requester.
- `quo  out  DATAWIDTH`: quotient. Holds its value until the next `done`.
- `rem  out  DATAWIDTH`: remainder. Holds its value until the next `done`.
- `div_by_zero  out  1`: qualifies `done`. Set when b was 0.
- `busy  out  1`: high in CALC and DONE.

## Operation
- FSM states:
  - IDLE → CALC on an edge with any `req` high.
  - CALC → DONE after the last iteration.
  - DONE → IDLE unconditionally.
- Arbitration:
  - In IDLE, the winner is the first requester with `req` high, scanning `ptr+1, ptr+2, …` modulo NREQ.
  - On grant: `ptr` takes the winner's index, its a/b are captured, and the winner's index is stored for `done`.
  - `ptr` resets to NREQ-1, so requester 0 has top priority first.
- `req` is ignored outside IDLE. A `req` still high when IDLE is re-entered counts as a new request.
- Division: unsigned restoring algorithm with one quotient bit per cycle, MSB first.
  - Partial remainder is DATAWIDTH+1 bits.
  - Each iteration: shift in the next dividend bit, subtract the divisor if the result is ≥0, and shift the quotient bit in.
- Divide by zero: CALC lasts exactly 1 cycle, then DONE with `quo`=all ones, `rem`=a, `div_by_zero`=1.
- `div_by_zero`=0 on every other `done`.
- Reset (any time, including mid-CALC):
  - State goes to IDLE, iteration counter and operand registers go to 0.
  - `gnt`, `done`, `busy`, `div_by_zero`, `quo`, `rem` all go to 0.
  - The in-flight operation is discarded and no `done` is issued for it.

## Timing
- All outputs are registered.
- Edge E0: IDLE with `req` sampled → capture. `gnt` is high in the cycle after E0, and `busy` rises at the same time.
- Normal divide: CALC occupies DATAWIDTH cycles (edges E1…E_DATAWIDTH).
  - `done` is high in the cycle after E_DATAWIDTH.
  - Capture-to-done latency is DATAWIDTH+1 edges.
- Divide by zero: `done` is high in the cycle after E1.
- Back-to-back operations: IDLE lasts one cycle after DONE.
  - Minimum issue interval is DATAWIDTH+2 cycles (normal) or 3 cycles (div-by-zero).
- Requesters must deassert `req` in the cycle they observe `gnt`, or they are treated as re-requesting.

## Structure
- Package `div_share_pkg` holds:
  - FSM state encoding (IDLE, CALC, DONE).
  - Counter width function `$clog2(DATAWIDTH+1)`.
  - Round-robin next-winner function.
- One sub-module, `div_iter_core`, contains:
  - Start/operand inputs.
  - Partial remainder, quotient and counter.
  - Output `last` flag and results.
- `div_share_ctrl` keeps the FSM, arbiter pointer, operand mux, and `gnt`/`done` generation.

## Test plan
All scenarios run at DATAWIDTH=8, NREQ=4.
- Single divide: req[0], a=100, b=7 → `gnt`=0001 for one cycle; `done`=0001 exactly 9 edges after capture, with `quo`=14, `rem`=2, `div_by_zero`=0.
- Fairness:
  - All four `req` high and held until granted, from reset → grant order 0,1,2,3, each separated by 10 cycles.
  - Then req[0] and req[2] together → order 0, 2.
- Divide by zero: req[1], a=55, b=0 → `done`=0010 two edges after capture, with `quo`=255, `rem`=55, `div_by_zero`=1.
- Edge operands:
  - a=255, b=1 → `quo`=255, `rem`=0.
  - a=3, b=200 → `quo`=0, `rem`=3.
  - a=0, b=9 → `quo`=0, `rem`=0.
- Reset mid-CALC: assert `Rst` low 4 cycles after grant → all outputs 0 immediately with no `done`. After release, req[3] and req[0] together → requester 0 is granted first.
- Stale request: req[2] held high through `done` with no other requesters → regranted 1 cycle after DONE, and a second `done`=0100 follows.
